// File: rtl/vector_pkg.sv
// Shared types and constants for the vector load path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: default lane count/width, register index width, packed vector
// type and the load FSM state encoding.
package vector_pkg;

    localparam int VEC_WIDTH  = 16;   // lanes per vector and bits per lane
    localparam int ADDR_W_DEF = 16;   // default data memory address width
    localparam int REG_IDX_W  = 5;    // vector register file index width

    typedef logic [VEC_WIDTH-1:0][VEC_WIDTH-1:0] vector_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        WRITE = 2'd3
    } vload_state_t;

endpackage

// File: rtl/vload_addr_gen.sv
// Lane address generator: latches base (and stride) on load, adds stride per step.
// Latency: address for the step-k cycle is registered, visible one cycle after load/step.
// Backpressure: none; steps only when told to by the owning FSM.
//
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   i_load       capture i_base/i_stride (has priority over i_step)
//   i_base       address of lane 0
//   i_stride     per-lane address increment (tied to 1 when striding is disabled)
//   i_step       advance the address by the latched stride
//   o_addr       current registered lane address
module vload_addr_gen #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_base,
    input  logic [ADDR_W-1:0] i_stride,
    input  logic              i_step,
    output logic [ADDR_W-1:0] o_addr
);

    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_stride;

    // Accumulator rather than base + k*stride: one adder, and the ADDR_W-bit
    // sum wraps modulo 2^ADDR_W for free.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr   <= '0;
            r_stride <= '0;
        end else if (i_load) begin
            r_addr   <= i_base;
            r_stride <= i_stride;
        end else if (i_step) begin
            r_addr   <= r_addr + r_stride;
        end
    end

    assign o_addr = r_addr;

endmodule

// File: rtl/vector_load_unit.sv
// Vector load: reads WIDTH consecutive lane words from data memory, packs them, writes the VRF.
// Latency: start (cycle 0) to WEV/done is WIDTH+2 cycles; next start accepted in cycle WIDTH+3.
// Backpressure: none; start is only sampled in IDLE, starts while busy are dropped.
//
// Build option: define VLOAD_STRIDE_EN to add the 'stride' input (lane k address
// = base + k*stride); without it the stride is fixed at 1. Timing is the same.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   start             load request (IDLE only); base_addr/rd_idx latched with it
//   stride            (VLOAD_STRIDE_EN only) lane address increment
//   busy              high from the cycle after an accepted start through WRITE
//   done              one-cycle pulse, coincident with WEV
//   mem_re/mem_addr   read request into a 1-cycle-latency synchronous RAM
//   mem_rdata         read data, valid the cycle after mem_re
//   WEV/RD/WD         single-cycle vector register file write
module vector_load_unit
    import vector_pkg::*;
#(
    parameter int WIDTH  = VEC_WIDTH,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [ADDR_W-1:0]           base_addr,
`ifdef VLOAD_STRIDE_EN
    input  logic [ADDR_W-1:0]           stride,
`endif
    input  logic [REG_IDX_W-1:0]        rd_idx,
    output logic                        busy,
    output logic                        done,
    output logic                        mem_re,
    output logic [ADDR_W-1:0]           mem_addr,
    input  logic [WIDTH-1:0]            mem_rdata,
    output logic                        WEV,
    output logic [REG_IDX_W-1:0]        RD,
    output logic [WIDTH-1:0][WIDTH-1:0] WD
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    vload_state_t               r_state;
    vload_state_t               w_state_nxt;
    logic [CNT_W-1:0]           r_cnt;        // issue index: cycle k of ISSUE has r_cnt = k-1
    logic                       r_busy;
    logic                       r_mem_re;
    logic                       r_write;      // drives both WEV and done
    logic [REG_IDX_W-1:0]       r_rd_lat;
    logic [REG_IDX_W-1:0]       r_rd;
    logic [WIDTH-1:0][WIDTH-1:0] r_wd;

    logic                       w_accept;
    logic                       w_step;
    logic                       w_cap_en;
    logic [CNT_W-1:0]           w_cap_idx;
    logic [ADDR_W-1:0]          w_stride;
    logic [ADDR_W-1:0]          w_mem_addr;

`ifdef VLOAD_STRIDE_EN
    assign w_stride = stride;
`else
    assign w_stride = ADDR_W'(1);
`endif

    assign w_accept = (r_state == IDLE) && start;

    vload_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_accept),
        .i_base   (base_addr),
        .i_stride (w_stride),
        .i_step   (w_step),
        .o_addr   (w_mem_addr)
    );

    // Next state plus per-cycle control. Read data trails the request by one
    // cycle, so ISSUE cycle k captures lane k-2 (nothing in the first ISSUE
    // cycle) and DRAIN picks up the final lane.
    always_comb begin
        w_state_nxt = r_state;
        w_step      = 1'b0;
        w_cap_en    = 1'b0;
        w_cap_idx   = r_cnt - CNT_W'(1);
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                w_step   = 1'b1;
                w_cap_en = (r_cnt != '0);
                if (r_cnt == CNT_W'(WIDTH - 1)) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                w_cap_en    = 1'b1;
                w_cap_idx   = CNT_W'(WIDTH - 1);
                w_state_nxt = WRITE;
            end
            WRITE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Status outputs are registered from the next state so they line up with
    // the state they describe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy   <= 1'b0;
            r_mem_re <= 1'b0;
            r_write  <= 1'b0;
        end else begin
            r_busy   <= (w_state_nxt != IDLE);
            r_mem_re <= (w_state_nxt == ISSUE);
            r_write  <= (w_state_nxt == WRITE);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt    <= '0;
            r_rd_lat <= '0;
        end else if (w_accept) begin
            r_cnt    <= '0;
            r_rd_lat <= rd_idx;
        end else if (r_state == ISSUE) begin
            // Wraps to 0 on entry to DRAIN; the value is unused until the next start.
            r_cnt    <= r_cnt + CNT_W'(1);
        end
    end

    // WD lanes are overwritten in place as the next load streams in; RD only
    // moves when the new vector is complete.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wd <= '0;
            r_rd <= '0;
        end else begin
            if (w_cap_en) begin
                r_wd[w_cap_idx] <= mem_rdata;
            end
            if (r_state == DRAIN) begin
                r_rd <= r_rd_lat;
            end
        end
    end

    assign busy     = r_busy;
    assign done     = r_write;
    assign WEV      = r_write;
    assign mem_re   = r_mem_re;
    assign mem_addr = w_mem_addr;
    assign RD       = r_rd;
    assign WD       = r_wd;

endmodule

// File: tb/tb_vector_load_unit.sv
// Bench for vector_load_unit: table of directed loads plus hand-written
// sequences for ignored starts, back-to-back loads and mid-load reset.
// Memory model: word at address A holds A + 0x100 (16-bit wrap).
module tb_vector_load_unit;

    localparam int W  = 16;
    localparam int AW = 16;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               start = 1'b0;
    logic [AW-1:0]      base_addr = '0;
    logic [AW-1:0]      stride = 16'h0001;
    logic [4:0]         rd_idx = '0;
    logic               busy;
    logic               done;
    logic               mem_re;
    logic [AW-1:0]      mem_addr;
    logic [W-1:0]       mem_rdata = '0;
    logic               WEV;
    logic [4:0]         RD;
    logic [W-1:0][W-1:0] WD;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    vector_load_unit #(
        .WIDTH  (W),
        .ADDR_W (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
`ifdef VLOAD_STRIDE_EN
        .stride    (stride),
`endif
        .rd_idx    (rd_idx),
        .busy      (busy),
        .done      (done),
        .mem_re    (mem_re),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .WEV       (WEV),
        .RD        (RD),
        .WD        (WD)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a + 16'h0100;
    endfunction

    // Synchronous-read RAM, one cycle of latency.
    always @(posedge clk) begin
        if (mem_re) mem_rdata <= mem_word(mem_addr);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Presents start in the current cycle (cycle 0) and follows the load until
    // WEV, sampling at each negedge. Optional pokes re-assert start with other
    // fields at the given cycle numbers; those must be ignored.
    task automatic run_load(input logic [15:0] b, input logic [4:0] r, input logic [15:0] s,
                            input int poke_a, input int poke_b,
                            output int wev_cyc, output int wev_glob, output int re_cnt,
                            output int addr_err, output int ctl_err);
        logic [15:0] exp_a;
        start = 1'b1; base_addr = b; rd_idx = r; stride = s;
        @(negedge clk);
        start = 1'b0;
        wev_cyc = -1; wev_glob = -1; re_cnt = 0; addr_err = 0; ctl_err = 0;
        for (int c = 1; c <= 40; c++) begin
            if (mem_re) begin
                exp_a = b + 16'(re_cnt) * s;
                if (mem_addr !== exp_a) addr_err++;
                re_cnt++;
            end
            if (busy !== (c <= W + 2)) ctl_err++;
            if (done !== WEV) ctl_err++;
            if (WEV) begin
                wev_cyc  = c;
                wev_glob = cyc;
                break;
            end
            start = (c == poke_a) || (c == poke_b);
            if (start) begin
                rd_idx = 5'd9; base_addr = 16'hAAAA; stride = 16'h0033;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic chk_vector(input string nm, input logic [15:0] b, input logic [15:0] s);
        int bad;
        bad = 0;
        for (int i = 0; i < W; i++) begin
            if (WD[i] !== mem_word(b + 16'(i) * s)) bad++;
        end
        chk({nm, "_lanes_bad"}, 32'(bad), 32'd0);
    endtask

    typedef struct {
        logic [15:0] base;
        logic [4:0]  rd;
        logic [15:0] stride;
        logic [15:0] w0;
        logic [15:0] w8;
        logic [15:0] w15;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int wc, wg, wg1, rc, ae, ce, cnt;

        tbl.push_back('{16'h0010, 5'd5,  16'h0001, 16'h0110, 16'h0118, 16'h011F});
        tbl.push_back('{16'hFFF8, 5'd3,  16'h0001, 16'h00F8, 16'h0100, 16'h0107});
        tbl.push_back('{16'h1234, 5'd31, 16'h0001, 16'h1334, 16'h133C, 16'h1343});
        tbl.push_back('{16'h0000, 5'd0,  16'h0001, 16'h0100, 16'h0108, 16'h010F});
`ifdef VLOAD_STRIDE_EN
        tbl.push_back('{16'h0100, 5'd12, 16'h0004, 16'h0200, 16'h0220, 16'h023C});
        tbl.push_back('{16'h0100, 5'd13, 16'h0000, 16'h0200, 16'h0200, 16'h0200});
`endif

        // Reset state, checked while reset is held.
        repeat (3) @(negedge clk);
        chk("rst_busy",   32'(busy),   32'd0);
        chk("rst_done",   32'(done),   32'd0);
        chk("rst_wev",    32'(WEV),    32'd0);
        chk("rst_mem_re", 32'(mem_re), 32'd0);
        chk("rst_addr",   32'(mem_addr), 32'd0);
        chk("rst_rd",     32'(RD),     32'd0);
        chk("rst_wd",     32'(WD != '0), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Table-driven loads.
        foreach (tbl[k]) begin
            run_load(tbl[k].base, tbl[k].rd, tbl[k].stride, -1, -1, wc, wg, rc, ae, ce);
            chk($sformatf("v%0d_latency", k), 32'(wc), 32'd18);
            chk($sformatf("v%0d_rd", k),      32'(RD), 32'(tbl[k].rd));
            chk($sformatf("v%0d_re_cycles", k), 32'(rc), 32'd16);
            chk($sformatf("v%0d_addr_err", k), 32'(ae), 32'd0);
            chk($sformatf("v%0d_ctl_err", k),  32'(ce), 32'd0);
            chk($sformatf("v%0d_wd0", k),  32'(WD[0]),  32'(tbl[k].w0));
            chk($sformatf("v%0d_wd8", k),  32'(WD[8]),  32'(tbl[k].w8));
            chk($sformatf("v%0d_wd15", k), 32'(WD[15]), 32'(tbl[k].w15));
            chk_vector($sformatf("v%0d", k), tbl[k].base, tbl[k].stride);
            @(negedge clk);
            chk($sformatf("v%0d_idle_busy", k), 32'(busy), 32'd0);
            chk($sformatf("v%0d_hold_rd", k),   32'(RD), 32'(tbl[k].rd));
        end

        // Starts at cycles 3 and 17 with rd_idx=9 must be ignored.
        run_load(16'h0010, 5'd5, 16'h0001, 3, 17, wc, wg, rc, ae, ce);
        chk("ign_latency",  32'(wc), 32'd18);
        chk("ign_rd",       32'(RD), 32'd5);
        chk("ign_addr_err", 32'(ae), 32'd0);
        chk("ign_ctl_err",  32'(ce), 32'd0);
        chk("ign_wd0",      32'(WD[0]), 32'h0110);
        chk("ign_wd15",     32'(WD[15]), 32'h011F);
        cnt = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (WEV || busy) cnt++;
        end
        chk("ign_no_second_wev", 32'(cnt), 32'd0);

        // Back-to-back: second start in the post-WRITE IDLE cycle.
        run_load(16'h0040, 5'd1, 16'h0001, -1, -1, wc, wg1, rc, ae, ce);
        chk("b2b_1_latency", 32'(wc), 32'd18);
        chk("b2b_1_rd",      32'(RD), 32'd1);
        chk_vector("b2b_1", 16'h0040, 16'h0001);
        @(negedge clk);
        run_load(16'h0300, 5'd2, 16'h0001, -1, -1, wc, wg, rc, ae, ce);
        chk("b2b_2_latency", 32'(wc), 32'd18);
        chk("b2b_spacing",   32'(wg - wg1), 32'd19);
        chk("b2b_2_rd",      32'(RD), 32'd2);
        chk("b2b_2_ctl_err", 32'(ce), 32'd0);
        chk_vector("b2b_2", 16'h0300, 16'h0001);
        @(negedge clk);

        // Reset at cycle 8 of a load aborts it.
        start = 1'b1; base_addr = 16'h0500; rd_idx = 5'd7; stride = 16'h0001;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        chk("abort_pre_busy", 32'(busy),   32'd1);
        chk("abort_pre_re",   32'(mem_re), 32'd1);
        rst = 1'b0;
        #1;
        chk("abort_busy",   32'(busy),   32'd0);
        chk("abort_mem_re", 32'(mem_re), 32'd0);
        chk("abort_wev",    32'(WEV),    32'd0);
        chk("abort_done",   32'(done),   32'd0);
        chk("abort_addr",   32'(mem_addr), 32'd0);
        chk("abort_rd",     32'(RD),     32'd0);
        chk("abort_wd",     32'(WD != '0), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        cnt = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (WEV || done || busy) cnt++;
        end
        chk("abort_no_wev", 32'(cnt), 32'd0);
        run_load(16'h0700, 5'd17, 16'h0001, -1, -1, wc, wg, rc, ae, ce);
        chk("post_rst_latency", 32'(wc), 32'd18);
        chk("post_rst_rd",      32'(RD), 32'd17);
        chk("post_rst_re",      32'(rc), 32'd16);
        chk("post_rst_wd3",     32'(WD[3]), 32'h0803);
        chk_vector("post_rst", 16'h0700, 16'h0001);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/vector_load_unit.md
Name: vector_load_unit

Overview:
- Sequential vector load stage that sits directly upstream of the vector register file.
- On a start request it reads WIDTH consecutive lane words from scalar data memory and packs them into one vector.
- It then drives a single-cycle write (WEV/RD/WD) into the register file.
- Memory is a synchronous-read RAM with a 1-cycle read latency.

Parameters:
WIDTH, 16, number of lanes per vector and bit width of each lane
ADDR_W, 16, data memory address width

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  asynchronous, active-low reset
start  input  1  load request, sampled only in IDLE
base_addr  input  ADDR_W  address of lane 0, latched on accepted start
rd_idx  input  5  destination vector register, latched on accepted start
busy  output  1  high from the cycle after an accepted start through the WRITE cycle
done  output  1  one-cycle pulse, coincident with WEV
mem_re  output  1  memory read enable
mem_addr  output  ADDR_W  memory read address
mem_rdata  input  WIDTH  read data, valid the cycle after mem_re
WEV  output  1  vector register file write enable
RD  output  5  vector register file destination index
WD  output  [WIDTH-1:0][WIDTH-1:0]  assembled vector; WD[i] is the word read from lane address i

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, lane counter=0, busy=0, done=0, WEV=0, mem_re=0, mem_addr=0, RD=0, WD=0. Outputs are registered.
- States: IDLE -> ISSUE -> DRAIN -> WRITE -> IDLE.
- Cycle 0, IDLE with start=1: latch base_addr and rd_idx; go to ISSUE.
- Cycles 1..WIDTH, ISSUE:
  - mem_re=1; mem_addr = base + (k-1) in cycle k, computed modulo 2^ADDR_W (wraps silently).
  - From cycle 2 onward, capture mem_rdata into WD[k-2].
- Cycle WIDTH+1, DRAIN: mem_re=0; capture the last lane into WD[WIDTH-1].
- Cycle WIDTH+2, WRITE: WEV=1 and done=1 for exactly one cycle; RD=latched rd_idx; WD holds the full vector.
- Cycle WIDTH+3: back in IDLE; busy=0; a new start is accepted in this cycle.
- start while busy is ignored. No queuing, and latched fields are not updated.
- WD and RD hold their values after WRITE until the next load completes lane captures. WD lanes are overwritten progressively during the next load.
- Reset asserted mid-operation aborts the load immediately: no WEV, no done, all outputs return to reset values.
- Latency from start to WEV is exactly WIDTH+2 cycles (18 with the default parameters).

Optional Feature:
- Macro VLOAD_STRIDE_EN.
- Defined: adds input port stride (ADDR_W bits, latched on an accepted start). Lane k address = base + k*stride modulo 2^ADDR_W, produced by an accumulator, not a multiplier. stride=0 loads one word broadcast to all lanes.
- Undefined: no stride port; stride is fixed at 1; timing is identical in both builds.

Decomposition:
- Shared package vector_pkg:
  - WIDTH default constant
  - REG_IDX_W=5
  - vector_t typedef ([WIDTH-1:0][WIDTH-1:0])
  - vload_state_t enum {IDLE, ISSUE, DRAIN, WRITE}
- One natural sub-module, vload_addr_gen: latches base (and stride) and steps the address per ISSUE cycle, with wrap. The FSM and lane capture stay in the top.

Test Plan:
- Memory word at address A holds A+0x100. start, base=0x0010, rd_idx=5 -> WEV=1 and done=1 exactly 18 cycles later; RD=5; WD[0]=0x0110, WD[15]=0x011F; mem_re high for 16 cycles.
- base=0xFFF8 -> mem_addr sequence 0xFFF8..0xFFFF then 0x0000..0x0007; WD[8] = word at address 0x0000.
- start pulsed again at cycles 3 and 17 with rd_idx=9 -> ignored; RD=5; no second WEV until a start arrives in the post-WRITE IDLE cycle.
- rst driven low at cycle 8 of a load -> busy, mem_re, WEV and WD all 0 immediately; no WEV ever follows; a new start after reset release completes normally.
- Back-to-back loads to rd_idx 1 then 2, second start in cycle WIDTH+3 -> two WEV pulses 19 cycles apart with correct independent vectors.
- VLOAD_STRIDE_EN build, base=0x0100, stride=0x0004 -> addresses 0x0100, 0x0104 .. 0x013C; stride=0 -> all 16 lanes equal word[0x0100].
